cp0_int_ctrl: RTL and testbench

Interrupt controller in front of CP0 in the cpu55 core. Synchronises external interrupt lines, keeps per-line pending bits (edge or level type) and applies the CP0 Status mask/IE. Raises one prioritised interrupt request to the pipeline's exception logic, then holds off further requests until the handler returns (no nesting).

---
 rtl/cp0_int_pkg.sv | 27 ++
 rtl/cp0_int_ctrl_irq_sync.sv | 36 +++
 rtl/cp0_int_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cp0_int_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_int_pkg.sv
// cp0_int_pkg: shared definitions for the CP0 interrupt controller.
//   - state_e   : controller FSM encoding (IDLE / REQ / SERVICE)
//   - defaults  : NUM_IRQ / CAUSE_W defaults
//   - prio_enc  : lowest-set-index priority encoder (index 0 wins)
package cp0_int_pkg;

    localparam int NUM_IRQ_DEF = 6;
    localparam int CAUSE_W_DEF = 3;
    localparam int IRQ_MAX     = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Scan from the top down so the lowest set index is the last one written.
    function automatic int prio_enc(input logic [IRQ_MAX-1:0] v);
        int idx;
        idx = 0;
        for (int i = IRQ_MAX - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cp0_int_ctrl_irq_sync.sv
// irq_sync: two-flop synchroniser for one raw interrupt line plus a
// rising-edge detector on the synchronised value.
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   d_i     raw asynchronous line
//   sync_o  synchronised level
//   rise_o  one-cycle pulse when sync_o goes 0 -> 1
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: interrupt controller in front of CP0.
// Synchronises the external lines, keeps per-line pending bits (edge-sticky
// or level), applies Status.IM / Status.IE and raises a single prioritised,
// non-nesting request towards the exception logic.
// Ports:
//   clk, rst              clock / asynchronous active-low reset
//   irq_in                raw interrupt lines (index 0 highest priority)
//   ie                    global enable (Status.IE)
//   mask_we, mask_wdata   mask register write
//   int_ack, eret         handler entry / return pulses
//   int_req, int_cause    registered request and its line index
//   pending, mask         Cause.IP mirror and current mask
//   in_service            high while the handler runs
//   cmp_we, cmp_wdata,    timer compare write and free-running counter,
//   count                 present only when TIMER_IRQ_EN is defined; the
//                         timer then owns line NUM_IRQ-1.
//
// state   | meaning
// IDLE    | evaluating pending & mask each cycle
// REQ     | int_req high, int_cause frozen, waiting for ack or withdraw
// SERVICE | handler running, no new requests until eret
module cp0_int_ctrl
    import cp0_int_pkg::*;
#(
    parameter int                 NUM_IRQ   = NUM_IRQ_DEF,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
    parameter int                 CAUSE_W   = CAUSE_W_DEF
`ifdef TIMER_IRQ_EN
    ,
    parameter int                 TIMER_W   = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ie,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               eret,
    output logic               int_req,
    output logic [CAUSE_W-1:0] int_cause,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic               in_service
`ifdef TIMER_IRQ_EN
    ,
    input  logic               cmp_we,
    input  logic [TIMER_W-1:0] cmp_wdata,
    output logic [TIMER_W-1:0] count
`endif
);

    logic [NUM_IRQ-1:0] sync;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pend_masked;
    logic [NUM_IRQ-1:0] cause_onehot;
    logic [NUM_IRQ-1:0] ack_clr;
    state_e             state_q;
    logic               int_req_q;
    logic [CAUSE_W-1:0] int_cause_q;
    logic               in_service_q;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .d_i    (irq_in[g]),
            .sync_o (sync[g]),
            .rise_o (rise[g])
        );
    end

    assign pend_masked  = pending_q & mask_q;
    assign cause_onehot = NUM_IRQ'(1) << int_cause_q;
    // Only an ack that the FSM actually accepts clears a sticky bit.
    assign ack_clr      = (state_q == ST_REQ && int_ack) ? cause_onehot : '0;

`ifdef TIMER_IRQ_EN
    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] cmp_q;
    logic               timer_hit;
    logic               unused_timer_line;

    assign timer_hit         = (count_q == cmp_q);
    // The timer replaces the external source on the top line.
    assign unused_timer_line = sync[NUM_IRQ-1] ^ rise[NUM_IRQ-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            cmp_q   <= '1;
        end else begin
            count_q <= count_q + TIMER_W'(1);
            if (cmp_we) cmp_q <= cmp_wdata;
        end
    end

    assign count = count_q;
`endif

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                // Set wins over a same-cycle clear.
                pending_d[i] = rise[i] | (pending_q[i] & ~ack_clr[i]);
            end else begin
                pending_d[i] = sync[i];
            end
        end
`ifdef TIMER_IRQ_EN
        // A compare write beats a same-cycle match.
        pending_d[NUM_IRQ-1] = cmp_we ? 1'b0
                             : (timer_hit | (pending_q[NUM_IRQ-1] & ~ack_clr[NUM_IRQ-1]));
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            int_req_q    <= 1'b0;
            int_cause_q  <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ie && (|pend_masked)) begin
                        state_q     <= ST_REQ;
                        int_req_q   <= 1'b1;
                        int_cause_q <= CAUSE_W'(prio_enc(IRQ_MAX'(pend_masked)));
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_q      <= ST_SERVICE;
                        int_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (!ie || !(|(pend_masked & cause_onehot))) begin
                        state_q   <= ST_IDLE;
                        int_req_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eret) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    int_req_q    <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_req    = int_req_q;
    assign int_cause  = int_cause_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl. Lines 0,1,2,4,5 are edge-type, line 3 is
// level-type. Inputs change on the falling edge, outputs are sampled on the
// falling edge or 1 time unit after the rising edge.
module tb_cp0_int_ctrl;

    localparam int         NI = 6;
    localparam logic [5:0] EM = 6'b110111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NI-1:0] irq_in = '0;
    logic          ie = 1'b0;
    logic          mask_we = 1'b0;
    logic [NI-1:0] mask_wdata = '0;
    logic          int_ack = 1'b0;
    logic          eret = 1'b0;
    logic          int_req;
    logic [2:0]    int_cause;
    logic [NI-1:0] pending;
    logic [NI-1:0] mask;
    logic          in_service;
`ifdef TIMER_IRQ_EN
    logic          cmp_we = 1'b0;
    logic [31:0]   cmp_wdata = '0;
    logic [31:0]   count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cp0_int_ctrl #(.NUM_IRQ(NI), .EDGE_MASK(EM), .CAUSE_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .ie         (ie),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_cause  (int_cause),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service)
`ifdef TIMER_IRQ_EN
        ,
        .cmp_we     (cmp_we),
        .cmp_wdata  (cmp_wdata),
        .count      (count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_mask(input logic [NI-1:0] m);
        @(negedge clk);
        mask_we    = 1'b1;
        mask_wdata = m;
        @(negedge clk);
        mask_we    = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic eret_pulse();
        @(negedge clk);
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
    endtask

    task automatic wait_req(input int maxc, input string name);
        int n;
        n = 0;
        while (!int_req && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(int_req), 64'd1);
    endtask

    typedef struct {
        logic [NI-1:0] irq;
        logic [NI-1:0] msk;
        logic          ie_v;
        logic [NI-1:0] exp_pend;
        logic          exp_req;
        logic [2:0]    exp_cause;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // irq        mask       ie    pending    req   cause
        vecs[0] = '{6'h00, 6'h3F, 1'b1, 6'h00, 1'b0, 3'd0};
        vecs[1] = '{6'h08, 6'h00, 1'b1, 6'h08, 1'b0, 3'd0};
        vecs[2] = '{6'h08, 6'h08, 1'b0, 6'h08, 1'b0, 3'd0};
        vecs[3] = '{6'h08, 6'h08, 1'b1, 6'h08, 1'b1, 3'd3};
        vecs[4] = '{6'h08, 6'h37, 1'b1, 6'h08, 1'b0, 3'd0};
        vecs[5] = '{6'h08, 6'h08, 1'b1, 6'h08, 1'b1, 3'd3};
        vecs[6] = '{6'h08, 6'h08, 1'b0, 6'h08, 1'b0, 3'd0};
        vecs[7] = '{6'h00, 6'h08, 1'b1, 6'h00, 1'b0, 3'd0};

        // ---- reset values
        repeat (3) @(negedge clk);
        check("rst_int_req", 64'(int_req), 64'd0);
        check("rst_cause", 64'(int_cause), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_mask", 64'(mask), 64'd0);
        check("rst_in_service", 64'(in_service), 64'd0);
`ifdef TIMER_IRQ_EN
        check("rst_count", 64'(count), 64'd0);
`endif
        rst = 1'b1;

        // ---- table: level line 3 against mask / ie gating and withdraw
        for (int i = 0; i < 8; i++) begin
            set_mask(vecs[i].msk);
            irq_in = vecs[i].irq;
            ie     = vecs[i].ie_v;
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d_pending", i), 64'(pending), 64'(vecs[i].exp_pend));
            check($sformatf("vec%0d_req", i), 64'(int_req), 64'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                check($sformatf("vec%0d_cause", i), 64'(int_cause), 64'(vecs[i].exp_cause));
        end

        // ---- latency on edge line 2, then ack / eret
        set_mask(6'h04);
        ie = 1'b1;
        @(negedge clk);
        irq_in[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lat_pend_e2", 64'(pending[2]), 64'd0);
        @(posedge clk); #1;
        check("lat_pend_e3", 64'(pending[2]), 64'd1);
        check("lat_req_e3", 64'(int_req), 64'd0);
        @(posedge clk); #1;
        check("lat_req_e4", 64'(int_req), 64'd1);
        check("lat_cause_e4", 64'(int_cause), 64'd2);
        @(negedge clk);
        irq_in[2] = 1'b0;
        ack_pulse();
        check("ack_req", 64'(int_req), 64'd0);
        check("ack_pend", 64'(pending[2]), 64'd0);
        check("ack_insvc", 64'(in_service), 64'd1);
        eret_pulse();
        check("eret_insvc", 64'(in_service), 64'd0);
        check("eret_req", 64'(int_req), 64'd0);

        // ---- priority and no preemption
        set_mask(6'h3F);
        @(negedge clk);
        irq_in[4] = 1'b1;
        irq_in[1] = 1'b1;
        wait_req(10, "prio_req");
        check("prio_cause1", 64'(int_cause), 64'd1);
        irq_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("nopreempt_req", 64'(int_req), 64'd1);
        check("nopreempt_cause", 64'(int_cause), 64'd1);
        check("nopreempt_pend", 64'(pending), 64'h13);
        ack_pulse();
        irq_in = '0;
        eret_pulse();
        check("gap_req_low", 64'(int_req), 64'd0);
        @(negedge clk);
        check("next_req0", 64'(int_req), 64'd1);
        check("next_cause0", 64'(int_cause), 64'd0);
        ack_pulse();
        eret_pulse();
        @(negedge clk);
        check("next_req4", 64'(int_req), 64'd1);
        check("next_cause4", 64'(int_cause), 64'd4);
        ack_pulse();
        eret_pulse();
        check("prio_pend_clear", 64'(pending), 64'd0);

        // ---- level line 3 withdraw without ack
        set_mask(6'h08);
        @(negedge clk);
        irq_in[3] = 1'b1;
        wait_req(10, "lvl_req");
        irq_in[3] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lvl_req_held", 64'(int_req), 64'd1);
        @(posedge clk); #1;
        check("lvl_req_drop", 64'(int_req), 64'd0);
        check("lvl_insvc", 64'(in_service), 64'd0);

        // ---- ie gating: request one edge after ie rises
        ie = 1'b0;
        irq_in[3] = 1'b1;
        repeat (6) @(negedge clk);
        check("ie0_req", 64'(int_req), 64'd0);
        ie = 1'b1;
        @(posedge clk); #1;
        check("ie1_req", 64'(int_req), 64'd1);
        @(negedge clk);
        irq_in[3] = 1'b0;
        repeat (6) @(negedge clk);

        // ---- edge on line 2 in the same cycle as its ack
        set_mask(6'h04);
        @(negedge clk);
        irq_in[2] = 1'b1;
        wait_req(10, "setclr_req");
        check("setclr_cause", 64'(int_cause), 64'd2);
        irq_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        irq_in[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        check("setclr_pend", 64'(pending[2]), 64'd1);
        check("setclr_insvc", 64'(in_service), 64'd1);
        check("setclr_req_low", 64'(int_req), 64'd0);
        irq_in[2] = 1'b0;
        eret_pulse();
        wait_req(4, "setclr_req2");
        check("setclr_cause2", 64'(int_cause), 64'd2);
        ack_pulse();
        eret_pulse();
        check("setclr_pend_end", 64'(pending), 64'd0);

`ifdef TIMER_IRQ_EN
        // ---- timer match on line 5
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cmp_we    = 1'b1;
        cmp_wdata = 32'd10;
        @(negedge clk);
        cmp_we = 1'b0;
        begin
            int n;
            n = 0;
            while (!pending[5] && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        check("tmr_pend", 64'(pending[5]), 64'd1);
        check("tmr_count", 64'(count), 64'd11);
        set_mask(6'h20);
        ie = 1'b1;
        wait_req(4, "tmr_req");
        check("tmr_cause", 64'(int_cause), 64'd5);
        @(negedge clk);
        cmp_we    = 1'b1;
        cmp_wdata = 32'd40;
        @(negedge clk);
        cmp_we = 1'b0;
        check("tmr_cmp_clr", 64'(pending[5]), 64'd0);
        @(negedge clk);
        check("tmr_withdraw", 64'(int_req), 64'd0);
`endif

        // ---- asynchronous reset while in REQ
        set_mask(6'h08);
        ie = 1'b1;
        @(negedge clk);
        irq_in[3] = 1'b1;
        wait_req(10, "rstreq_req");
        #2;
        rst = 1'b0;
        #1;
        check("arst_req", 64'(int_req), 64'd0);
        check("arst_cause", 64'(int_cause), 64'd0);
        check("arst_pend", 64'(pending), 64'd0);
        check("arst_mask", 64'(mask), 64'd0);
        check("arst_insvc", 64'(in_service), 64'd0);
`ifdef TIMER_IRQ_EN
        check("arst_count", 64'(count), 64'd0);
`endif
        irq_in = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
